serial_transmitter: RTL

//   Transmit side of the team's asynchronous serial link. It serializes one byte per request

---
 rtl/serial_transmitter_pkg.sv | 24 ++
 rtl/serial_transmitter_bit_timer.sv | 34 +++
 rtl/serial_transmitter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/serial_transmitter_pkg.sv
// Shared frame constants, state encoding and sizing helper for the serial link.
// The receiver imports the same package, so frame levels and defaults stay in one place.
package serial_transmitter_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic int unsigned count_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/serial_transmitter_bit_timer.sv
// Free-running 0..OVERSAMPLE-1 cycle counter; bit_tick marks the last cycle of each bit.
// clear restarts the count so a frame's bit boundaries align to its request.
import serial_transmitter_pkg::*;

module bit_timer #(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    output logic bit_tick,
    input  logic clear,
    input  logic sample_clk,
    input  logic reset
);

    localparam int unsigned CW = count_width(OVERSAMPLE);
    localparam logic [CW-1:0] LAST_COUNT = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] count_r;

    // Cycle counter, wrapping at the end of each bit period.
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (count_r == LAST_COUNT) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign bit_tick = (count_r == LAST_COUNT);

endmodule

// File: rtl/serial_transmitter.sv
// Transmit side of the async serial link: idle-high, start/data(LSB first)/stop framing.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
import serial_transmitter_pkg::*;

module serial_transmitter #(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 sample_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 send,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned BC_W = count_width(DATA_BITS);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

    tx_state_e            state_r, state_s;
    logic [DATA_BITS-1:0] shreg_r, shreg_s;
    logic [BC_W-1:0]      bit_count_r, bit_count_s;
    logic                 tx_r, tx_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 clear_s;
    logic                 bit_tick_s;
`ifdef SERIAL_TX_PARITY_EN
    logic                 parity_r, parity_s;

    function automatic logic parity_even(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .bit_tick   (bit_tick_s),
        .clear      (clear_s),
        .sample_clk (sample_clk),
        .reset      (reset)
    );

    // Next-state and next-output logic; tx is computed one cycle ahead so it leaves a flop.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        bit_count_s = bit_count_r;
        tx_s        = tx_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        clear_s     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_s    = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                tx_s = IDLE_LEVEL;
                if (send) begin
                    shreg_s     = din;
                    bit_count_s = {BC_W{1'b0}};
                    tx_s        = START_BIT;
                    busy_s      = 1'b1;
                    clear_s     = 1'b1;
                    state_s     = ST_START;
`ifdef SERIAL_TX_PARITY_EN
                    parity_s    = parity_even(din);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    tx_s    = shreg_r[0];
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    shreg_s     = shreg_r >> 1;
                    bit_count_s = bit_count_r + BC_W'(1);
                    if (bit_count_r == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        tx_s    = parity_r;
                        state_s = ST_PARITY;
`else
                        tx_s    = STOP_BIT;
                        state_s = ST_STOP;
`endif
                    end else begin
                        tx_s = shreg_s[0];
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick_s) begin
                    tx_s    = STOP_BIT;
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick_s) begin
                    tx_s    = IDLE_LEVEL;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                tx_s    = IDLE_LEVEL;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset drops the line high immediately.
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            shreg_r     <= {DATA_BITS{1'b0}};
            bit_count_r <= {BC_W{1'b0}};
            tx_r        <= IDLE_LEVEL;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            bit_count_r <= bit_count_s;
            tx_r        <= tx_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
`ifdef SERIAL_TX_PARITY_EN
            parity_r    <= parity_s;
`endif
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
